// File: rtl/commit_trace_serializer.sv
// Serializes up to two retired register writes per cycle into a one-record-per-cycle debug trace.
// Head record reaches the outputs one edge after enqueue; stall warns at DEPTH-1, and records without room are dropped into sticky overflow.
module commit_trace_serializer #(
   parameter int DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in0_valid,
   input  logic        in0_wen,
   input  logic [4:0]  in0_rd,
   input  logic [31:0] in0_wdata,
   input  logic [31:0] in0_pc,
   input  logic        in1_valid,
   input  logic        in1_wen,
   input  logic [4:0]  in1_rd,
   input  logic [31:0] in1_wdata,
   input  logic [31:0] in1_pc,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata,
   output logic        stall,
   output logic        overflow,
   output logic [31:0] commit_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } rec_t;

   rec_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   occ_q, occ_d, room;
   logic          vld_q, ovf_q;
   rec_t          out_q, head, rec0, rec1, first_dat;
   logic [31:0]   cnt_q;
   logic          q0, q1, acc0, acc1, pop, drop, first_en, second_en;

   always_comb begin
      q0   = in0_valid & in0_wen & (in0_rd != 5'd0);
      q1   = in1_valid & in1_wen & (in1_rd != 5'd0);
      pop  = (occ_q != '0);
      // The same-cycle dequeue frees a slot before the pushes are counted.
      room = FULL - occ_q + (AW+1)'(pop);
      acc0 = q0 & (room != '0);
      acc1 = q1 & (acc0 ? (room > (AW+1)'(1)) : (room != '0));
      drop = (q0 & ~acc0) | (q1 & ~acc1);
      rec0 = '{pc: in0_pc, rd: in0_rd, wdata: in0_wdata};
      rec1 = '{pc: in1_pc, rd: in1_rd, wdata: in1_wdata};
      first_en  = acc0 | acc1;
      first_dat = acc0 ? rec0 : rec1;
      second_en = acc0 & acc1;
      occ_d    = occ_q - (AW+1)'(pop) + (AW+1)'(acc0) + (AW+1)'(acc1);
      wr_ptr_d = wr_ptr_q + AW'(acc0) + AW'(acc1);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      head     = mem_q[rd_ptr_q];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         if (first_en)  mem_q[wr_ptr_q]          <= first_dat;
         if (second_en) mem_q[wr_ptr_q + AW'(1)] <= rec1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         occ_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         vld_q    <= 1'b0;
         out_q    <= '0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         occ_q    <= occ_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         vld_q    <= pop;
         if (pop) out_q <= head;
         ovf_q    <= ovf_q | drop;
         cnt_q    <= cnt_q + 32'(in0_valid) + 32'(in1_valid);
      end
   end

   assign debug_wb_pc       = out_q.pc;
   assign debug_wb_rf_wnum  = out_q.rd;
   assign debug_wb_rf_wdata = out_q.wdata;
   assign debug_wb_rf_wen   = {4{vld_q}};
   assign stall             = (occ_q >= (AW+1)'(DEPTH-1));
   assign overflow          = ovf_q;
   assign commit_cnt        = cnt_q;
endmodule

// File: tb/tb_commit_trace_serializer.sv
// Directed plus random bench for commit_trace_serializer with a queue scoreboard of expected trace records.
module tb_commit_trace_serializer;
   localparam int DEPTH = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } rec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        in0_valid, in0_wen, in1_valid, in1_wen;
   logic [4:0]  in0_rd, in1_rd;
   logic [31:0] in0_wdata, in0_pc, in1_wdata, in1_pc;
   logic [31:0] debug_wb_pc, debug_wb_rf_wdata, commit_cnt;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic        stall, overflow;

   rec_t        exp_q[$];
   rec_t        last_rec;
   logic        m_ovf;
   logic [31:0] m_cnt;
   int          checks = 0;
   int          errors = 0;

   commit_trace_serializer #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .in0_valid(in0_valid), .in0_wen(in0_wen), .in0_rd(in0_rd), .in0_wdata(in0_wdata), .in0_pc(in0_pc),
      .in1_valid(in1_valid), .in1_wen(in1_wen), .in1_rd(in1_rd), .in1_wdata(in1_wdata), .in1_pc(in1_pc),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
      .debug_wb_rf_wdata(debug_wb_rf_wdata), .stall(stall), .overflow(overflow), .commit_cnt(commit_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input logic popped);
      chk("wen",      32'(debug_wb_rf_wen), popped ? 32'hf : 32'h0);
      chk("pc",       debug_wb_pc, last_rec.pc);
      chk("wnum",     32'(debug_wb_rf_wnum), 32'(last_rec.rd));
      chk("wdata",    debug_wb_rf_wdata, last_rec.wdata);
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("cnt",      commit_cnt, m_cnt);
      chk("stall",    32'(stall), (exp_q.size() >= DEPTH-1) ? 32'h1 : 32'h0);
   endtask

   // One clock of commit traffic; the queue front leaves first, then new records claim free room.
   task automatic cyc(input logic v0, input logic w0, input logic [4:0] r0, input logic [31:0] d0, input logic [31:0] p0,
                      input logic v1, input logic w1, input logic [4:0] r1, input logic [31:0] d1, input logic [31:0] p1);
      logic popped;
      rec_t head;
      int   free;
      in0_valid = v0; in0_wen = w0; in0_rd = r0; in0_wdata = d0; in0_pc = p0;
      in1_valid = v1; in1_wen = w1; in1_rd = r1; in1_wdata = d1; in1_pc = p1;
      popped = (exp_q.size() > 0);
      head   = '0;
      if (popped) head = exp_q.pop_front();
      free = DEPTH - exp_q.size();
      if (v0 && w0 && r0 != 5'd0) begin
         if (free > 0) begin
            exp_q.push_back('{pc: p0, rd: r0, wdata: d0});
            free--;
         end else m_ovf = 1'b1;
      end
      if (v1 && w1 && r1 != 5'd0) begin
         if (free > 0) exp_q.push_back('{pc: p1, rd: r1, wdata: d1});
         else m_ovf = 1'b1;
      end
      m_cnt = m_cnt + 32'(v0) + 32'(v1);
      @(posedge clock);
      @(negedge clock);
      if (popped) last_rec = head;
      check_outputs(popped);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
   endtask

   task automatic do_rst();
      reset = 1'b1;
      in0_valid = 1'b1; in0_wen = 1'b1; in0_rd = 5'd9;  in0_wdata = $urandom; in0_pc = $urandom;
      in1_valid = 1'b1; in1_wen = 1'b1; in1_rd = 5'd10; in1_wdata = $urandom; in1_pc = $urandom;
      @(posedge clock);
      @(negedge clock);
      exp_q.delete();
      last_rec = '0;
      m_ovf    = 1'b0;
      m_cnt    = 32'h0;
      check_outputs(1'b0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      in0_valid = 1'b0; in0_wen = 1'b0; in0_rd = 5'd0; in0_wdata = 32'h0; in0_pc = 32'h0;
      in1_valid = 1'b0; in1_wen = 1'b0; in1_rd = 5'd0; in1_wdata = 32'h0; in1_pc = 32'h0;
      last_rec = '0; m_ovf = 1'b0; m_cnt = 32'h0;
      @(negedge clock);
      do_rst();
      do_rst();

      // Single record, then hold
      cyc(1'b1, 1'b1, 5'd5, 32'h11, 32'hbfc00000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      idle(); idle();

      // Dual same-cycle records
      cyc(1'b1, 1'b1, 5'd2, 32'h22, 32'hbfc00004, 1'b1, 1'b1, 5'd3, 32'h33, 32'hbfc00008);
      idle(); idle(); idle();

      // Filtered slots only bump the commit counter
      cyc(1'b1, 1'b1, 5'd0, 32'h44, 32'hbfc0000c, 1'b1, 1'b0, 5'd3, 32'h55, 32'hbfc00010);
      idle();

      // Only slot 1 qualifies
      cyc(1'b1, 1'b0, 5'd4, 32'h66, 32'hbfc00014, 1'b1, 1'b1, 5'd6, 32'h77, 32'hbfc00018);
      idle(); idle();

      // Fill to exactly DEPTH, single push while full, then a dual push that drops slot 1
      for (int i = 0; i < 7; i++)
         cyc(1'b1, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 32'h1000 + 32'(8 * i),
             1'b1, 1'b1, 5'(i + 11), 32'h200 + 32'(i), 32'h1004 + 32'(8 * i));
      cyc(1'b1, 1'b1, 5'd20, 32'h300, 32'h2000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      cyc(1'b1, 1'b1, 5'd21, 32'h301, 32'h2004, 1'b1, 1'b1, 5'd22, 32'h302, 32'h2008);
      cyc(1'b1, 1'b1, 5'd23, 32'h303, 32'h200c, 1'b1, 1'b1, 5'd24, 32'h304, 32'h2010);
      for (int i = 0; i < 10; i++) idle();

      // Random traffic after a clean reset
      do_rst();
      for (int i = 0; i < 80; i++)
         cyc(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom, $urandom,
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom, $urandom);
      for (int i = 0; i < 10; i++) idle();

      // Reset with five records queued, then a fresh record
      do_rst();
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b1, 5'(i + 1), 32'h400 + 32'(i), 32'h3000 + 32'(8 * i),
             1'b1, 1'b1, 5'(i + 5), 32'h500 + 32'(i), 32'h3004 + 32'(8 * i));
      do_rst();
      idle();
      cyc(1'b1, 1'b1, 5'd7, 32'hdead, 32'hbfc00100, 1'b1, 1'b1, 5'd8, 32'hbeef, 32'hbfc00104);
      idle(); idle(); idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
